// File: rtl/uart_program_loader.sv
// UART boot loader: receives a magic-framed program image over an 8N1 RX pin and writes it
// word-by-word into memory through a req/gnt port, holding the core in reset while loading.
module uart_program_loader #(
    parameter int                BAUD_DIV  = 868,
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h4000_0000),
    parameter int                MAX_WORDS = 65536,
    parameter int                TIMEOUT_B = 16,
    parameter logic [31:0]       MAGIC     = 32'hB007_C0DE
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_i,
    output logic              prog_mode_o,
    output logic              core_rst_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    output logic              err_o,
    output logic [1:0]        err_code_o
);

    localparam int BYTES    = DATA_W / 8;
    localparam int HALF_DIV = BAUD_DIV / 2;
    localparam int CNT_W    = $clog2(BAUD_DIV);
    localparam int TO_CYC   = TIMEOUT_B * 10 * BAUD_DIV;
    localparam int TO_W     = $clog2(TO_CYC + 1);

    localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(BYTES);
    localparam logic [31:0]       MAX_LEN = 32'(MAX_WORDS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_REL   = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    localparam logic [1:0] ERR_FRAME = 2'd1;
    localparam logic [1:0] ERR_OVR   = 2'd2;
    localparam logic [1:0] ERR_LEN   = 2'd3;

    // Little-endian assembly: each new byte enters at the top and older bytes move down.
    function automatic logic [DATA_W-1:0] shift_in_word(input logic [DATA_W-1:0] w,
                                                        input logic [7:0] b);
        return (w >> 8) | (DATA_W'(b) << (DATA_W - 8));
    endfunction

    logic             rx_s1, rx_s2, rx_s3;
    logic             rx_busy, rx_done, rx_ferr;
    logic [CNT_W-1:0] rx_cnt;
    logic [3:0]       rx_bit;
    logic [7:0]       rx_sh;
    logic [7:0]       byte_buf;
    logic             byte_vld;

    logic [2:0]       state;
    logic [31:0]      window, len_sh, cnt, idx;
    logic [2:0]       nbytes;
    logic [TO_W-1:0]  to_cnt;

    logic             take, overrun, in_frame, timeout, err_evt;
    logic [1:0]       err_sel;
    logic [31:0]      window_next, len_next;

    // RX: synchroniser, falling-edge start detect, mid-bit sampling of start/data/stop
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_s3   <= 1'b1;
            rx_busy <= 1'b0;
            rx_cnt  <= '0;
            rx_bit  <= '0;
            rx_done <= 1'b0;
            rx_ferr <= 1'b0;
        end else begin
            rx_s1   <= rx_i;
            rx_s2   <= rx_s1;
            rx_s3   <= rx_s2;
            rx_done <= 1'b0;
            rx_ferr <= 1'b0;
            if (!rx_busy) begin
                if (rx_s3 && !rx_s2) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= CNT_W'(HALF_DIV - 1);
                    rx_bit  <= '0;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - 1'b1;
            end else begin
                rx_cnt <= CNT_W'(BAUD_DIV - 1);
                rx_bit <= rx_bit + 4'd1;
                if (rx_bit == 4'd0 && rx_s2) begin
                    rx_busy <= 1'b0;          // start bit gone by mid-bit: glitch
                end else if (rx_bit == 4'd9) begin
                    rx_busy <= 1'b0;
                    rx_done <= rx_s2;
                    rx_ferr <= !rx_s2;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rx_busy && rx_cnt == '0 && rx_bit >= 4'd1 && rx_bit <= 4'd8)
            rx_sh <= {rx_s2, rx_sh[7:1]};
        if (rx_done)
            byte_buf <= rx_sh;
        if (take && state == S_LEN)
            len_sh <= len_next;
    end

    // The FSM drains the holding buffer only in states that consume bytes.
    assign take     = byte_vld && (state == S_IDLE || state == S_LEN || state == S_DATA);
    assign overrun  = rx_done && byte_vld && !take;
    assign in_frame = (state == S_LEN) || (state == S_DATA);
    assign timeout  = in_frame && !take && (to_cnt == TO_W'(TO_CYC - 1));
    assign err_evt  = rx_ferr || overrun || timeout;
    assign err_sel  = rx_ferr ? ERR_FRAME : (overrun ? ERR_OVR : ERR_LEN);

    assign window_next = {byte_buf, window[31:8]};
    assign len_next    = {byte_buf, len_sh[31:8]};
    assign mem_we_o    = mem_req_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            byte_vld <= 1'b0;
            to_cnt   <= '0;
        end else begin
            if (rx_done)
                byte_vld <= 1'b1;
            else if (take)
                byte_vld <= 1'b0;
            if (!in_frame || take)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
        end
    end

    // Frame FSM
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            window      <= '0;
            nbytes      <= '0;
            cnt         <= '0;
            idx         <= '0;
            prog_mode_o <= 1'b0;
            core_rst_o  <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            err_o       <= 1'b0;
            err_code_o  <= 2'd0;
        end else if (err_evt && (in_frame || state == S_WRITE)) begin
            // Abort: drop any pending request, keep the core held in reset.
            state       <= S_ERR;
            mem_req_o   <= 1'b0;
            prog_mode_o <= 1'b0;
            err_o       <= 1'b1;
            err_code_o  <= err_sel;
        end else begin
            if (err_evt) begin
                err_o      <= 1'b1;
                err_code_o <= err_sel;
            end
            case (state)
                S_IDLE: begin
                    if (take) begin
                        window <= window_next;
                        if (window_next == MAGIC) begin
                            window      <= '0;
                            prog_mode_o <= 1'b1;
                            core_rst_o  <= 1'b1;
                            err_o       <= 1'b0;
                            err_code_o  <= 2'd0;
                            nbytes      <= '0;
                            state       <= S_LEN;
                        end
                    end
                end
                S_LEN: begin
                    if (take) begin
                        nbytes <= nbytes + 3'd1;
                        if (nbytes == 3'd3) begin
                            nbytes <= '0;
                            if (len_next == 32'd0 || len_next > MAX_LEN) begin
                                state       <= S_ERR;
                                prog_mode_o <= 1'b0;
                                err_o       <= 1'b1;
                                err_code_o  <= ERR_LEN;
                            end else begin
                                cnt        <= len_next;
                                idx        <= '0;
                                mem_addr_o <= BASE_ADDR;
                                state      <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (take) begin
                        mem_wdata_o <= shift_in_word(mem_wdata_o, byte_buf);
                        nbytes      <= nbytes + 3'd1;
                        if (nbytes == 3'(BYTES - 1)) begin
                            nbytes    <= '0;
                            mem_req_o <= 1'b1;
                            state     <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (mem_gnt_i) begin
                        mem_req_o  <= 1'b0;
                        idx        <= idx + 32'd1;
                        mem_addr_o <= mem_addr_o + STRIDE;
                        state      <= (idx + 32'd1 == cnt) ? S_DONE : S_DATA;
                    end
                end
                S_DONE: begin
                    prog_mode_o <= 1'b0;
                    state       <= S_REL;
                end
                S_REL: begin
                    core_rst_o <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
